dragon_length_scheduler: RTL

- Sequences the dragon body datapath. Generates its movement_counter from vsync.
- Collects asynchronous grow and shrink game events and arbitrates them into single-cycle States commands.
- Issues at most one command per movement step, aligned to the step boundary, and tracks the current body length.
- Sits between the game-event logic (sheep eaten, player hit) and the dragon segment pipeline.

---
 rtl/dragon_length_scheduler_pkg.sv | 34 +++
 rtl/dragon_length_scheduler_if.sv | 31 +++
 rtl/dragon_length_scheduler_frame_tick_gen.sv | 58 +++++
 rtl/dragon_length_scheduler.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dragon_length_scheduler_pkg.sv
// Shared definitions for the dragon length scheduler and the segment datapath.
// Holds command codes, FSM encodings, widths and the length limits.
package dragon_pkg;

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned PEND_W = 3;

    localparam int unsigned MAX_LEN_DEF = 7;
    localparam int unsigned MIN_LEN_DEF = 1;

    localparam logic [1:0] CMD_NONE   = 2'b00;
    localparam logic [1:0] CMD_GROW   = 2'b01;
    localparam logic [1:0] CMD_SHRINK = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Saturating request counter update; a simultaneous inc and dec cancel out.
    function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                    input logic inc,
                                                    input logic dec);
        logic [PEND_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec && (cur != '1)) begin
            nxt = cur + PEND_W'(1);
        end else if (dec && !inc) begin
            nxt = cur - PEND_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dragon_length_scheduler_if.sv
// Game-event / datapath bus of the dragon length scheduler.
// The master side is the game logic, the slave side is the scheduler.
interface dragon_length_scheduler_if;
    import dragon_pkg::*;

    logic                vsync;
    logic                en;
    logic                grow_req;
    logic                shrink_req;
    logic [1:0]          States;
    logic [CNT_W-1:0]    movement_counter;
    logic                move_tick;
    logic [LEN_W-1:0]    dragon_len;
    logic [PEND_W-1:0]   pend_grow;
    logic [PEND_W-1:0]   pend_shrink;
    logic                drop_pulse;
    logic                dead;

    modport master (
        output vsync, en, grow_req, shrink_req,
        input  States, movement_counter, move_tick, dragon_len,
               pend_grow, pend_shrink, drop_pulse, dead
    );

    modport slave (
        input  vsync, en, grow_req, shrink_req,
        output States, movement_counter, move_tick, dragon_len,
               pend_grow, pend_shrink, drop_pulse, dead
    );

endinterface

// File: rtl/dragon_length_scheduler_frame_tick_gen.sv
// vsync synchronizer, frame edge detect and wrapping movement counter.
// Reusable by every mover that steps on the frame-derived movement period.
module frame_tick_gen
    import dragon_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync_i,
    input  logic             en_i,
    input  logic             restart_i,
    output logic [CNT_W-1:0] movement_counter_o,
    output logic             move_tick_o
);

    logic             sync1_q, sync2_q, edge_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             frame_tick;

    assign frame_tick = sync2_q & ~edge_q;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i && frame_tick) begin
            if (cnt_q == CNT_W'(MOVE_PERIOD)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= vsync_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign movement_counter_o = cnt_q;
    assign move_tick_o        = tick_q;

endmodule

// File: rtl/dragon_length_scheduler.sv
// Arbitrates grow/shrink game events into one datapath command per movement step
// and tracks the committed dragon body length.
module dragon_length_scheduler
    import dragon_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD = 20,
    parameter int unsigned MAX_LEN     = MAX_LEN_DEF,
    parameter int unsigned MIN_LEN     = MIN_LEN_DEF,
    parameter int unsigned INIT_LEN    = 1,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    dragon_length_scheduler_if.slave bus
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic              en_q, en_rise;
    logic [1:0]        state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              rr_last_q, rr_last_d;       // 1: last round-robin winner was shrink
    logic              sel_shrink_q, sel_shrink_d;
    logic [PEND_W-1:0] pg_q, pg_d, ps_q, ps_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              drop_q, drop_d, dead_q, dead_d;
    logic              move_tick;
    logic [CNT_W-1:0]  movement_counter;
    logic              inc_g, inc_s, dec_g, dec_s, sel;

    assign en_rise = bus.en & ~en_q;

    frame_tick_gen #(
        .MOVE_PERIOD(MOVE_PERIOD)
    ) u_frame_tick_gen (
        .clk                (clk),
        .reset              (reset),
        .vsync_i            (bus.vsync),
        .en_i               (bus.en),
        .restart_i          (en_rise),
        .movement_counter_o (movement_counter),
        .move_tick_o        (move_tick)
    );

    // The grant decision is taken on move_tick so States is registered in the GRANT cycle;
    // the pending counter is consumed at the end of GRANT.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        rr_last_d    = rr_last_q;
        sel_shrink_d = sel_shrink_q;
        pg_d         = pg_q;
        ps_d         = ps_q;
        len_d        = len_q;
        cmd_d        = CMD_NONE;
        drop_d       = 1'b0;
        dead_d       = dead_q;
        inc_g        = bus.grow_req & ~dead_q;
        inc_s        = bus.shrink_req & ~dead_q;
        dec_g        = 1'b0;
        dec_s        = 1'b0;
        sel          = 1'b0;

        if (!bus.en) begin
            state_d = ST_IDLE;
            gap_d   = '0;
            pg_d    = '0;
            ps_d    = '0;
            if (en_q) begin
                dead_d = 1'b0;
            end
        end else begin
            if (en_rise) begin
                len_d  = LEN_W'(INIT_LEN);
                dead_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (move_tick && !dead_q && ((pg_q != '0) || (ps_q != '0))) begin
                        if ((pg_q != '0) && (ps_q != '0)) begin
                            sel       = ~rr_last_q;
                            rr_last_d = sel;
                        end else begin
                            sel = (ps_q != '0);
                        end
                        sel_shrink_d = sel;
                        state_d      = ST_GRANT;
                        if (!sel) begin
                            if (len_q < LEN_W'(MAX_LEN)) begin
                                cmd_d = CMD_GROW;
                                len_d = len_q + LEN_W'(1);
                            end else begin
                                drop_d = 1'b1;
                            end
                        end else if (len_q > LEN_W'(MIN_LEN)) begin
                            cmd_d = CMD_SHRINK;
                            len_d = len_q - LEN_W'(1);
                        end else begin
                            drop_d = 1'b1;
                            dead_d = 1'b1;
                        end
                    end
                end
                ST_GRANT: begin
                    dec_g   = ~sel_shrink_q;
                    dec_s   = sel_shrink_q;
                    gap_d   = '0;
                    state_d = dead_q ? ST_IDLE : ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            pg_d = pend_next(pg_q, inc_g, dec_g);
            ps_d = pend_next(ps_q, inc_s, dec_s);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q         <= 1'b0;
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            rr_last_q    <= 1'b1;
            sel_shrink_q <= 1'b0;
            pg_q         <= '0;
            ps_q         <= '0;
            len_q        <= LEN_W'(INIT_LEN);
            cmd_q        <= CMD_NONE;
            drop_q       <= 1'b0;
            dead_q       <= 1'b0;
        end else begin
            en_q         <= bus.en;
            state_q      <= state_d;
            gap_q        <= gap_d;
            rr_last_q    <= rr_last_d;
            sel_shrink_q <= sel_shrink_d;
            pg_q         <= pg_d;
            ps_q         <= ps_d;
            len_q        <= len_d;
            cmd_q        <= cmd_d;
            drop_q       <= drop_d;
            dead_q       <= dead_d;
        end
    end

    assign bus.States           = cmd_q;
    assign bus.movement_counter = movement_counter;
    assign bus.move_tick        = move_tick;
    assign bus.dragon_len       = len_q;
    assign bus.pend_grow        = pg_q;
    assign bus.pend_shrink      = ps_q;
    assign bus.drop_pulse       = drop_q;
    assign bus.dead             = dead_q;

endmodule
